// File: rtl/jtag_master_shift.sv
// rtl/jtag_master_shift.sv - JTAG initiator: sequences TCK/TMS/TDI per command and captures TDO
module jtag_master_shift #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic [4:0]         tap_state,
    output logic               jtag_clk,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2;

    localparam logic [4:0] S_TLR = 5'd0, S_RTI = 5'd1, S_SDR = 5'd2, S_CDR = 5'd3,
                           S_SHDR = 5'd4, S_E1DR = 5'd5, S_PDR = 5'd6, S_E2DR = 5'd7,
                           S_UDR = 5'd8, S_SIR = 5'd9, S_CIR = 5'd10, S_SHIR = 5'd11,
                           S_E1IR = 5'd12, S_PIR = 5'd13, S_E2IR = 5'd14, S_UIR = 5'd15;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_TCK_LOW, ST_TCK_HIGH, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [6:0]         len_q, total_q, total_d, bit_q, len_in;
    logic               pre_q, pre_d;
    logic [MAX_LEN-1:0] data_q, rsp_q;
    logic [DW-1:0]      div_q;
    logic               accept, phase_end, last_bit, is_shift_op;
    logic [6:0]         sched_k, sched_j, sched_base, sched_off, cap_base, cap_off;
    logic               sched_pre, sched_tms, sched_tdi, cap_en;

    function automatic logic [4:0] tap_next(input logic [4:0] s, input logic tms);
        case (s)
            S_TLR:   tap_next = tms ? S_TLR  : S_RTI;
            S_RTI:   tap_next = tms ? S_SDR  : S_RTI;
            S_SDR:   tap_next = tms ? S_SIR  : S_CDR;
            S_CDR:   tap_next = tms ? S_E1DR : S_SHDR;
            S_SHDR:  tap_next = tms ? S_E1DR : S_SHDR;
            S_E1DR:  tap_next = tms ? S_UDR  : S_PDR;
            S_PDR:   tap_next = tms ? S_E2DR : S_PDR;
            S_E2DR:  tap_next = tms ? S_UDR  : S_SHDR;
            S_UDR:   tap_next = tms ? S_SDR  : S_RTI;
            S_SIR:   tap_next = tms ? S_TLR  : S_CIR;
            S_CIR:   tap_next = tms ? S_E1IR : S_SHIR;
            S_SHIR:  tap_next = tms ? S_E1IR : S_SHIR;
            S_E1IR:  tap_next = tms ? S_UIR  : S_PIR;
            S_PIR:   tap_next = tms ? S_E2IR : S_PIR;
            S_E2IR:  tap_next = tms ? S_UIR  : S_SHIR;
            S_UIR:   tap_next = tms ? S_SDR  : S_RTI;
            default: tap_next = S_TLR;
        endcase
    endfunction

    assign phase_end   = (div_q == DIV_LAST);
    assign last_bit    = (bit_q == total_q - 7'd1);
    assign is_shift_op = (op_q == OP_IR) || (op_q == OP_DR);
    assign pre_d       = (tap_state == S_TLR) && (op_q != OP_RESET);
    assign rsp_data    = rsp_q;

    always_comb begin
        len_in = {1'b0, cmd_len};
        if (len_in > LEN_MAX) len_in = LEN_MAX;
        if (len_in == 7'd0 && (cmd_op == OP_IR || cmd_op == OP_DR)) len_in = 7'd1;
    end

    always_comb begin
        case (op_q)
            OP_RESET: total_d = 7'd6;
            OP_IR:    total_d = {6'd0, pre_d} + len_q + 7'd6;
            OP_DR:    total_d = {6'd0, pre_d} + len_q + 7'd5;
            default:  total_d = (len_q == 7'd0) ? 7'd0 : {6'd0, pre_d} + len_q;
        endcase
    end

    // TMS/TDI for the TCK about to start: bit 0 while in LOAD, otherwise the one after bit_q
    always_comb begin
        sched_pre  = (state_q == ST_LOAD) ? pre_d : pre_q;
        sched_k    = (state_q == ST_LOAD) ? 7'd0 : bit_q + 7'd1;
        sched_j    = sched_k - {6'd0, sched_pre};
        sched_base = {6'd0, sched_pre} + ((op_q == OP_IR) ? 7'd4 : 7'd3);
        sched_off  = sched_k - sched_base;
        sched_tms  = 1'b0;
        sched_tdi  = 1'b0;
        case (op_q)
            OP_RESET: sched_tms = (sched_k < 7'd5);
            OP_IR, OP_DR: begin
                if (sched_k < {6'd0, sched_pre})
                    sched_tms = 1'b0;
                else if (sched_k < sched_base)
                    sched_tms = (sched_j == 7'd0) || (op_q == OP_IR && sched_j == 7'd1);
                else if (sched_k + 7'd1 < sched_base + len_q)
                    sched_tms = 1'b0;
                else
                    sched_tms = (sched_k <= sched_base + len_q);
                if (sched_k >= sched_base && sched_k < sched_base + len_q)
                    sched_tdi = |(data_q & (MAX_LEN'(1) << sched_off));
            end
            default: sched_tms = 1'b0;
        endcase
    end

    assign cap_base = {6'd0, pre_q} + ((op_q == OP_IR) ? 7'd4 : 7'd3);
    assign cap_off  = bit_q - cap_base;
    assign cap_en   = is_shift_op && (bit_q >= cap_base) && (bit_q < cap_base + len_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                state_d = (total_d == 7'd0) ? ST_DONE : ST_TCK_LOW;
            end
            ST_TCK_LOW: begin
                busy = 1'b1;
                if (phase_end) state_d = ST_TCK_HIGH;
            end
            ST_TCK_HIGH: begin
                busy = 1'b1;
                if (phase_end) state_d = last_bit ? ST_DONE : ST_TCK_LOW;
            end
            ST_DONE: begin
                cmd_ready = 1'b1;
                rsp_valid = 1'b1;
                accept    = cmd_valid;
                state_d   = cmd_valid ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            op_q      <= 2'd0;
            len_q     <= 7'd0;
            data_q    <= '0;
            pre_q     <= 1'b0;
            total_q   <= 7'd0;
            bit_q     <= 7'd0;
            div_q     <= '0;
            rsp_q     <= '0;
            tap_state <= S_TLR;
            jtag_clk  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                len_q  <= len_in;
                data_q <= cmd_data;
            end
            case (state_q)
                ST_LOAD: begin
                    pre_q   <= pre_d;
                    total_q <= total_d;
                    bit_q   <= 7'd0;
                    div_q   <= '0;
                    rsp_q   <= '0;
                    if (total_d != 7'd0) begin
                        jtag_tms <= sched_tms;
                        jtag_tdi <= sched_tdi;
                    end
                end
                ST_TCK_LOW: begin
                    div_q <= phase_end ? '0 : div_q + DW'(1);
                    if (phase_end) begin
                        jtag_clk  <= 1'b1;
                        tap_state <= tap_next(tap_state, jtag_tms);
                    end
                end
                ST_TCK_HIGH: begin
                    div_q <= phase_end ? '0 : div_q + DW'(1);
                    if (phase_end) begin
                        jtag_clk <= 1'b0;
                        bit_q    <= bit_q + 7'd1;
                        if (cap_en && jtag_tdo) rsp_q <= rsp_q | (MAX_LEN'(1) << cap_off);
                        // the final TMS level is left on the pin after the last TCK
                        if (!last_bit) begin
                            jtag_tms <= sched_tms;
                            jtag_tdi <= sched_tdi;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
